// File: rtl/seg7_pkg.sv
// Shared types and glyph table for the multiplexed 7-segment scan driver.
// Glyph bit order is {e,d,c,b,a,f,g}, active-high.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0011000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b0111101;
    localparam logic [6:0] SEG_4     = 7'b0011011;
    localparam logic [6:0] SEG_5     = 7'b0110111;
    localparam logic [6:0] SEG_6     = 7'b1110111;
    localparam logic [6:0] SEG_7     = 7'b0011100;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b0111111;
    localparam logic [6:0] SEG_A     = 7'b1011111;
    localparam logic [6:0] SEG_B     = 7'b1110011;
    localparam logic [6:0] SEG_C     = 7'b1100110;
    localparam logic [6:0] SEG_D     = 7'b1111001;
    localparam logic [6:0] SEG_E     = 7'b1100111;
    localparam logic [6:0] SEG_F     = 7'b1000111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_e;

    typedef struct packed {
        scan_state_e state;
        logic        pending;
    } seg7_dbg_t;

    function automatic logic [6:0] seg7_glyph(input logic [3:0] nibble, input logic hex_en);
        logic [6:0] g;
        case (nibble)
            4'h0: g = SEG_0;
            4'h1: g = SEG_1;
            4'h2: g = SEG_2;
            4'h3: g = SEG_3;
            4'h4: g = SEG_4;
            4'h5: g = SEG_5;
            4'h6: g = SEG_6;
            4'h7: g = SEG_7;
            4'h8: g = SEG_8;
            4'h9: g = SEG_9;
            4'hA: g = hex_en ? SEG_A : SEG_BLANK;
            4'hB: g = hex_en ? SEG_B : SEG_BLANK;
            4'hC: g = hex_en ? SEG_C : SEG_BLANK;
            4'hD: g = hex_en ? SEG_D : SEG_BLANK;
            4'hE: g = hex_en ? SEG_E : SEG_BLANK;
            default: g = hex_en ? SEG_F : SEG_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Bus between the CPU/debug side (master) and the scan driver (slave).
// load is a fire-and-forget strobe with no ready: it is accepted on every cycle it is high.
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    import seg7_pkg::*;

    logic                      enable;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   value;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic                      lz_blank;
    logic [6:0]                seg;
    logic                      dp;
    logic [NUM_DIGITS-1:0]     an;
    logic                      frame_done;
    seg7_dbg_t                 dbg;

    modport master (
        output enable, load, value, dp_in, lz_blank,
        input  seg, dp, an, frame_done, dbg
    );

    modport slave (
        input  enable, load, value, dp_in, lz_blank,
        output seg, dp, an, frame_done, dbg
    );

endinterface

// File: rtl/seg7_decoder.sv
// Combinational nibble-to-glyph decoder; hex_en selects A..F glyphs or blank.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       hex_en_i,
    output logic [6:0] seg_o
);

    assign seg_o = seg7_glyph(nibble_i, hex_en_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with dead time, leading-zero blanking
// and frame-aligned display updates.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 8,
    parameter bit HEX_EN       = 1'b0
) (
    input logic              clk,
    input logic              rst_n,
    seg7_scan_driver_if.slave bus
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VAL_W = 4 * NUM_DIGITS;

    scan_state_e            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;

    logic [VAL_W-1:0]       pend_val_q, pend_val_d, disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0]  pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
    logic                   pend_lz_q, pend_lz_d, disp_lz_q, disp_lz_d;
    logic                   pend_flag_q, pend_flag_d;

    logic [6:0]             seg_q, seg_d;
    logic                   dp_q, dp_d;
    logic [NUM_DIGITS-1:0]  an_q, an_d;
    logic                   fd_q, fd_d;

    logic [NUM_DIGITS-1:0]  lz_dark;
    logic [3:0]             nibble;
    logic [6:0]             glyph;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        if (!bus.enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            if (state_q == ST_IDLE) begin
                cnt_d = '0;
                idx_d = '0;
            end else if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
                cnt_d = '0;
                idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            state_d = (int'(cnt_d) < BLANK_CYCLES) ? ST_BLANK : ST_DRIVE;
        end
    end

    // Display only follows pending at a frame boundary or while dark, so a frame never tears.
    always_comb begin
        pend_val_d  = pend_val_q;
        pend_dp_d   = pend_dp_q;
        pend_lz_d   = pend_lz_q;
        pend_flag_d = pend_flag_q;
        disp_val_d  = disp_val_q;
        disp_dp_d   = disp_dp_q;
        disp_lz_d   = disp_lz_q;
        if (bus.load) begin
            pend_val_d  = bus.value;
            pend_dp_d   = bus.dp_in;
            pend_lz_d   = bus.lz_blank;
            pend_flag_d = 1'b1;
        end
        if (!bus.enable || fd_q) begin
            disp_val_d  = pend_val_d;
            disp_dp_d   = pend_dp_d;
            disp_lz_d   = pend_lz_d;
            pend_flag_d = 1'b0;
        end
    end

    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        lz_dark  = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run   = zero_run & (disp_val_d[4*k +: 4] == 4'h0);
            lz_dark[k] = disp_lz_d && (k != 0) && zero_run;
        end
    end

    assign nibble = disp_val_d[4*idx_d +: 4];

    seg7_decoder u_dec (
        .nibble_i (nibble),
        .hex_en_i (HEX_EN),
        .seg_o    (glyph)
    );

    // Outputs are computed from next-state values so they switch on the same edge as the counters.
    always_comb begin
        an_d  = '0;
        seg_d = SEG_BLANK;
        dp_d  = 1'b0;
        fd_d  = (state_d != ST_IDLE) && (cnt_d == CNT_W'(REFRESH_DIV - 1))
                && (idx_d == IDX_W'(NUM_DIGITS - 1));
        if (state_d == ST_DRIVE) begin
            an_d  = NUM_DIGITS'(1) << idx_d;
            seg_d = lz_dark[idx_d] ? SEG_BLANK : glyph;
            dp_d  = disp_dp_d[idx_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_val_q  <= '0;
            pend_dp_q   <= '0;
            pend_lz_q   <= 1'b0;
            pend_flag_q <= 1'b0;
            disp_val_q  <= '0;
            disp_dp_q   <= '0;
            disp_lz_q   <= 1'b0;
            seg_q       <= SEG_BLANK;
            dp_q        <= 1'b0;
            an_q        <= '0;
            fd_q        <= 1'b0;
        end else begin
            pend_val_q  <= pend_val_d;
            pend_dp_q   <= pend_dp_d;
            pend_lz_q   <= pend_lz_d;
            pend_flag_q <= pend_flag_d;
            disp_val_q  <= disp_val_d;
            disp_dp_q   <= disp_dp_d;
            disp_lz_q   <= disp_lz_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            an_q        <= an_d;
            fd_q        <= fd_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.an         = an_q;
    assign bus.frame_done = fd_q;
    assign bus.dbg        = seg7_dbg_t'{state: state_q, pending: pend_flag_q};

endmodule
